branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage counterpart of the fetch-side predictor.
- Compares each resolved branch against the prediction carried down the pipe and raises a one-cycle flush with the correct redirect PC on a mispredict.
- Produces write-back updates for the BHT (2-bit saturating counter) and BTB (target), buffered in a small FIFO drained over a valid/ready handshake to the predictor tables.
- Sits between the EX stage and the IF-stage PC/BHT/BTB.

Parameters:
- DEPTH, 4, update-FIFO entries (power of two, ≥2).
- SQUASH_CYCLES, 2, cycles of wrong-path EX input ignored after a flush (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX holds a valid instruction
- ex_is_branch  in  1  instruction is a conditional branch or jump
- ex_pc  in  32  branch PC
- ex_taken  in  1  actual outcome
- ex_target  in  32  actual taken target
- ex_pred_taken  in  1  taken prediction made at fetch
- ex_pred_target  in  32  target predicted at fetch
- ex_pred_ctr  in  2  BHT counter value read at fetch
- flush  out  1  squash younger stages, one-cycle pulse
- redirect_pc  out  32  correct next PC, valid while flush=1
- upd_valid  out  1  FIFO head valid
- upd_ready  in  1  tables accept update
- upd_pc  out  32  PC to update
- upd_ctr  out  2  new counter value
- upd_btb_we  out  1  write BTB entry
- upd_target  out  32  BTB target
- fifo_full  out  1  FIFO occupancy == DEPTH

Behaviour:
- Reset: flush=0, redirect_pc=0, upd_valid=0, upd_pc/upd_ctr/upd_target=0, upd_btb_we=0, fifo_full=0; FIFO empty; FSM in RUN; squash counter=0. Reset mid-operation discards all queued updates.
- Accept condition: ex_valid && ex_is_branch && state==RUN.
- Mispredict: (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_taken && ex_pred_target != ex_target).
- Redirect:
  - On an accepted mispredict, in the next cycle: flush=1 and redirect_pc = ex_taken ? ex_target : ex_pc+4 (mod 2^32, wraps silently).
  - flush is high for exactly one cycle.
- FSM:
  - RUN → SQUASH on an accepted mispredict; counter loaded with SQUASH_CYCLES.
  - SQUASH: all EX inputs ignored (no flush, no push); counter decrements each cycle; → RUN in the cycle the counter reaches 0. A branch presented on the first RUN cycle is accepted.
- Counter update: taken → min(ex_pred_ctr+1, 3); not taken → max(ex_pred_ctr-1, 0). 2-bit saturating, no wrap.
- Push: every accepted branch, correct or not, pushes {ex_pc, new ctr, ex_taken as btb_we, ex_target}. The entry is visible at the head no earlier than the next cycle.
- Pop: upd_valid && upd_ready. Outputs show the FIFO head directly (show-ahead); outputs are held stable while upd_valid=1 && upd_ready=0.
- Full:
  - A push when full and not popping in the same cycle is dropped. The update is lost; flush/redirect are still generated.
  - Push and pop in the same cycle at full: both occur, occupancy unchanged.
- Empty: upd_valid=0; upd_ready is ignored.
- Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Non-branch instructions and ex_valid=0: no effect.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined:
  - Adds outputs stat_branches (32), stat_mispredicts (32), stat_drops (16).
  - Counters increment on accepted branch, accepted mispredict, and dropped push respectively.
  - Saturating (no wrap); reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Correct not-taken: pc=0x100, pred_taken=0, taken=0, pred_ctr=1 → no flush; one cycle later upd_valid=1, upd_pc=0x100, upd_ctr=0, upd_btb_we=0.
- Direction mispredict: pc=0x200, pred_taken=0, taken=1, target=0x400, ctr=1 → next cycle flush=1, redirect_pc=0x400; update ctr=2, btb_we=1, target=0x400; a branch presented in the following 2 cycles produces no flush and no push.
- Target mispredict: pred_taken=1, taken=1, pred_target=0x500, target=0x600 → flush, redirect_pc=0x600; not-taken mispredict at pc=0xFFFFFFFC → redirect_pc=0x00000000.
- Saturation: ctr=3 with taken → upd_ctr=3; ctr=0 with not taken → upd_ctr=0.
- Backpressure: upd_ready=0, 5 correctly predicted branches → fifo_full=1 after 4; 5th dropped; release ready → exactly 4 updates drain in push order, head stable while stalled; with BRU_STATS_EN, stat_drops=1.
- Reset mid-operation: 3 queued entries plus SQUASH active, assert rst → next cycle upd_valid=0, flush=0, state RUN; a branch accepted immediately after reset deasserts.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch check, mispredict flush/redirect, BHT/BTB update FIFO.
// Optional BRU_STATS_EN adds saturating branch/mispredict/drop counters.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic [1:0]  ex_pred_ctr,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [31:0] upd_pc,
  output logic [1:0]  upd_ctr,
  output logic        upd_btb_we,
  output logic [31:0] upd_target,
  output logic        fifo_full
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
  output logic [15:0] stat_drops
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SQUASH_CYCLES + 1);
  typedef enum logic {RUN, SQUASH} state_t;
  state_t state;
  logic [SW-1:0] sq_cnt;
  logic [31:0] mem_pc [DEPTH];
  logic [31:0] mem_target [DEPTH];
  logic [1:0] mem_ctr [DEPTH];
  logic mem_we [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic accept, mispredict, pop, push;
  logic [1:0] new_ctr;
  always_comb begin
    accept = ex_valid && ex_is_branch && state == RUN;
    mispredict = (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_taken && ex_pred_target != ex_target);
    new_ctr = ex_taken ? (ex_pred_ctr == 2'd3 ? 2'd3 : ex_pred_ctr + 2'd1)
                       : (ex_pred_ctr == 2'd0 ? 2'd0 : ex_pred_ctr - 2'd1);
    upd_valid = count != '0;
    fifo_full = count == (AW+1)'(DEPTH);
    pop = upd_valid && upd_ready;
    push = accept && (!fifo_full || pop);
    upd_pc = upd_valid ? mem_pc[rd_ptr] : '0;
    upd_ctr = upd_valid ? mem_ctr[rd_ptr] : '0;
    upd_btb_we = upd_valid ? mem_we[rd_ptr] : 1'b0;
    upd_target = upd_valid ? mem_target[rd_ptr] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      sq_cnt <= '0;
      flush <= 1'b0;
      redirect_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      flush <= accept && mispredict;
      if (accept && mispredict) begin
        redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
        state <= SQUASH;
        sq_cnt <= SW'(SQUASH_CYCLES);
      end else if (state == SQUASH) begin
        sq_cnt <= sq_cnt - SW'(1);
        if (sq_cnt == SW'(1)) state <= RUN;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= push && !pop ? count + (AW+1)'(1) : !push && pop ? count - (AW+1)'(1) : count;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr] <= ex_pc;
      mem_ctr[wr_ptr] <= new_ctr;
      mem_we[wr_ptr] <= ex_taken;
      mem_target[wr_ptr] <= ex_target;
    end
  end
`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispredicts <= '0;
      stat_drops <= '0;
    end else begin
      if (accept && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (accept && mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
      if (accept && fifo_full && !pop && stat_drops != '1) stat_drops <= stat_drops + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic [1:0] ex_pred_ctr = '0;
  logic upd_ready = 1'b0;
  logic flush, upd_valid, upd_btb_we, fifo_full;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [1:0] upd_ctr;
  int n_vec = 0, n_err = 0;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
  logic [15:0] stat_drops;
`endif
  branch_resolve_unit #(.DEPTH(4), .SQUASH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_pred_ctr(ex_pred_ctr), .flush(flush),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_ctr(upd_ctr), .upd_btb_we(upd_btb_we), .upd_target(upd_target), .fifo_full(fifo_full)
`ifdef BRU_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts), .stat_drops(stat_drops)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    if (o !== e) begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", t, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                    input logic ptk, input logic [31:0] ptg, input logic [1:0] ctr);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tg;
    ex_pred_taken = ptk; ex_pred_target = ptg; ex_pred_ctr = ctr;
  endtask
  task automatic idle;
    ex_valid = 1'b0; ex_is_branch = 1'b0;
  endtask
  task automatic pop1;
    upd_ready = 1'b1; tick; upd_ready = 1'b0;
  endtask
  initial begin
    #100000;
    n_err++;
    $error("FAIL timeout: test did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    tick; tick;
    rst = 1'b0;
    chk("rst_flush", flush, 1'b0);
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_valid", upd_valid, 1'b0);
    chk("rst_pc", upd_pc, 32'h0);
    chk("rst_ctr", upd_ctr, 2'd0);
    chk("rst_we", upd_btb_we, 1'b0);
    chk("rst_target", upd_target, 32'h0);
    chk("rst_full", fifo_full, 1'b0);
    br(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 2'd1); tick; idle;
    chk("nt_flush", flush, 1'b0);
    chk("nt_valid", upd_valid, 1'b1);
    chk("nt_pc", upd_pc, 32'h100);
    chk("nt_ctr", upd_ctr, 2'd0);
    chk("nt_we", upd_btb_we, 1'b0);
    pop1;
    chk("nt_popped", upd_valid, 1'b0);
    br(32'h200, 1'b1, 32'h400, 1'b0, 32'h0, 2'd1); tick;
    chk("dir_flush", flush, 1'b1);
    chk("dir_redirect", redirect_pc, 32'h400);
    chk("dir_pc", upd_pc, 32'h200);
    chk("dir_ctr", upd_ctr, 2'd2);
    chk("dir_we", upd_btb_we, 1'b1);
    chk("dir_target", upd_target, 32'h400);
    br(32'h300, 1'b1, 32'h900, 1'b0, 32'h0, 2'd0); tick;
    chk("sq1_flush", flush, 1'b0);
    tick;
    chk("sq2_flush", flush, 1'b0);
    br(32'h340, 1'b0, 32'h0, 1'b0, 32'h0, 2'd2); tick; idle;
    chk("run_flush", flush, 1'b0);
    chk("sq_head", upd_pc, 32'h200);
    pop1;
    chk("run_pc", upd_pc, 32'h340);
    chk("run_ctr", upd_ctr, 2'd1);
    pop1;
    chk("sq_nopush", upd_valid, 1'b0);
    br(32'h480, 1'b1, 32'h600, 1'b1, 32'h500, 2'd2); tick; idle;
    chk("tgt_flush", flush, 1'b1);
    chk("tgt_redirect", redirect_pc, 32'h600);
    chk("tgt_ctr", upd_ctr, 2'd3);
    chk("tgt_target", upd_target, 32'h600);
    tick; tick; pop1;
    br(32'hFFFFFFFC, 1'b0, 32'h1234, 1'b1, 32'h1234, 2'd2); tick; idle;
    chk("wrap_flush", flush, 1'b1);
    chk("wrap_redirect", redirect_pc, 32'h0);
    chk("wrap_ctr", upd_ctr, 2'd1);
    chk("wrap_we", upd_btb_we, 1'b0);
    chk("wrap_target", upd_target, 32'h1234);
    tick; tick; pop1;
    br(32'h700, 1'b1, 32'h800, 1'b1, 32'h800, 2'd3); tick; idle;
    chk("sat_hi_flush", flush, 1'b0);
    chk("sat_hi_ctr", upd_ctr, 2'd3);
    pop1;
    br(32'h704, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0); tick; idle;
    chk("sat_lo_ctr", upd_ctr, 2'd0);
    pop1;
    br(32'h708, 1'b1, 32'h900, 1'b0, 32'h0, 2'd1); ex_is_branch = 1'b0; tick; idle;
    chk("nonbr_flush", flush, 1'b0);
    chk("nonbr_valid", upd_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      br(32'h1000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0, 2'd1); tick;
      if (i == 2) chk("bp_notfull", fifo_full, 1'b0);
      if (i == 3) chk("bp_full", fifo_full, 1'b1);
    end
    idle;
    chk("bp_full_after", fifo_full, 1'b1);
    chk("bp_head", upd_pc, 32'h1000);
    tick;
    chk("bp_stable", upd_pc, 32'h1000);
`ifdef BRU_STATS_EN
    chk("stat_drops", stat_drops, 16'd1);
`endif
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", upd_valid, 1'b1);
      chk("bp_drain_pc", upd_pc, 32'h1000 + 32'(i * 4));
      tick;
    end
    upd_ready = 1'b0;
    chk("bp_empty", upd_valid, 1'b0);
    chk("bp_unfull", fifo_full, 1'b0);
    for (int i = 0; i < 4; i++) begin
      br(32'h2000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0, 2'd1); tick;
    end
    br(32'h2010, 1'b0, 32'h0, 1'b0, 32'h0, 2'd1); upd_ready = 1'b1; tick; upd_ready = 1'b0; idle;
    chk("pp_full", fifo_full, 1'b1);
    upd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("pp_drain_pc", upd_pc, 32'h2000 + 32'(i * 4));
      tick;
    end
    upd_ready = 1'b0;
    chk("pp_empty", upd_valid, 1'b0);
    br(32'h3000, 1'b0, 32'h0, 1'b0, 32'h0, 2'd1); tick;
    br(32'h3004, 1'b0, 32'h0, 1'b0, 32'h0, 2'd1); tick;
    br(32'h3008, 1'b1, 32'h3100, 1'b0, 32'h0, 2'd1); tick; idle;
    chk("mid_flush", flush, 1'b1);
    rst = 1'b1; tick; rst = 1'b0;
    chk("mid_rst_valid", upd_valid, 1'b0);
    chk("mid_rst_flush", flush, 1'b0);
    chk("mid_rst_full", fifo_full, 1'b0);
`ifdef BRU_STATS_EN
    chk("mid_rst_drops", stat_drops, 16'd0);
    chk("mid_rst_branches", stat_branches, 32'd0);
`endif
    br(32'h3200, 1'b1, 32'h3300, 1'b0, 32'h0, 2'd1); tick; idle;
    chk("post_rst_flush", flush, 1'b1);
    chk("post_rst_redirect", redirect_pc, 32'h3300);
    chk("post_rst_pc", upd_pc, 32'h3200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
